icache_assoc: RTL and testbench

//  Parametrised set-associative instruction cache between datapath fetch and memory arbiter.

---
 rtl/icache_assoc.sv | 189 ++++++++++++++++++
 tb/tb_icache_assoc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways, multi-word blocks) with an LRU victim and a word-by-word refill FSM.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_assoc #(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W   = $clog2(BLKWORDS);
    localparam int WC_W    = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BLKWORDS - 1);

    generate
        if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
            $error("icache_assoc: WAYS must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state_q, state_d;
    logic [WC_W-1:0]  wordcnt_q, wordcnt_d;
    logic [TAG_W-1:0] ltag_q, ltag_d;
    logic [IDX_W-1:0] lidx_q, lidx_d;
    logic             victim_q, victim_d;

    logic [WAYS-1:0][SETS-1:0]                    valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0][TAG_W-1:0]         tag_q, tag_d;
    logic [WAYS-1:0][SETS-1:0][BLKWORDS-1:0][31:0] data_q, data_d;
    logic [SETS-1:0]                              lru_q, lru_d;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [WC_W-1:0]  req_off;
    logic             hit_any;
    logic             hit_way;
    logic             pick_way;
    logic             lookup_hit;
    logic             unused_addr_bits;

    assign req_tag = TAG_W'(imemaddr >> TAG_LSB);
    assign req_idx = IDX_W'(imemaddr >> IDX_LSB);
    assign req_off = WC_W'((imemaddr >> 2) & 32'(BLKWORDS - 1));
    assign unused_addr_bits = ^imemaddr[1:0];

    // Lowest-numbered matching way wins, though at most one can match.
    always_comb begin
        hit_any = 1'b0;
        hit_way = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // An invalid way is always preferred over evicting live data.
    always_comb begin
        pick_way = lru_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                pick_way = 1'(w);
            end
        end
        if (WAYS == 1) begin
            pick_way = 1'b0;
        end
    end

    assign lookup_hit = (state_q == IDLE) && imemREN && hit_any;
    assign ihit       = lookup_hit;
    assign imemload   = lookup_hit ? data_q[hit_way][req_idx][req_off] : 32'd0;
    assign iREN       = (state_q == REFILL);
    assign iaddr      = (state_q == REFILL)
                        ? ((32'(ltag_q) << TAG_LSB) | (32'(lidx_q) << IDX_LSB) | (32'(wordcnt_q) << 2))
                        : 32'd0;

    always_comb begin
        state_d   = state_q;
        wordcnt_d = wordcnt_q;
        ltag_d    = ltag_q;
        lidx_d    = lidx_q;
        victim_d  = victim_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        lru_d     = lru_q;
`ifdef ICACHE_STATS_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (lookup_hit) begin
                    lru_d[req_idx] = ~hit_way;
`ifdef ICACHE_STATS_EN
                    hit_count_d = hit_count_q + 32'd1;
`endif
                end else if (imemREN) begin
                    ltag_d    = req_tag;
                    lidx_d    = req_idx;
                    victim_d  = pick_way;
                    wordcnt_d = '0;
                    state_d   = REFILL;
`ifdef ICACHE_STATS_EN
                    miss_count_d = miss_count_q + 32'd1;
`endif
                end
            end
            REFILL: begin
                if (!iwait) begin
                    data_d[victim_q][lidx_q][wordcnt_q] = iload;
                    wordcnt_d = wordcnt_q + 1'b1;
                    // Valid and tag flip only here, so a partially filled line never hits.
                    if (wordcnt_q == LAST_WORD) begin
                        valid_d[victim_q][lidx_q] = 1'b1;
                        tag_d[victim_q][lidx_q]   = ltag_q;
                        lru_d[lidx_q]             = ~victim_q;
                        wordcnt_d                 = '0;
                        state_d                   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            wordcnt_q <= '0;
            ltag_q    <= '0;
            lidx_q    <= '0;
            victim_q  <= 1'b0;
            valid_q   <= '0;
            lru_q     <= '0;
`ifdef ICACHE_STATS_EN
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            wordcnt_q <= wordcnt_d;
            ltag_q    <= ltag_d;
            lidx_q    <= lidx_d;
            victim_q  <= victim_d;
            valid_q   <= valid_d;
            lru_q     <= lru_d;
`ifdef ICACHE_STATS_EN
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed-vector bench for icache_assoc (SETS=8, WAYS=2, BLKWORDS=2); memory returns addr + 0x1000_0000.
// Statistics checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_assoc;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;

    icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(2)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: every word's contents are its address plus a fixed offset.
    assign iload = iaddr + 32'h1000_0000;

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        imemREN = 1'b0;
        iwait   = 1'b0;
        cycle();
        nRST = 1'b1;
    endtask

    // Requests addr until it hits; cyc is the observation index of the hit, -1 on timeout.
    task automatic fill_line(input logic [31:0] addr, output int cyc);
        cyc      = -1;
        imemREN  = 1'b1;
        imemaddr = addr;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ihit === 1'b1) begin
                cyc = i;
                break;
            end
            cycle();
        end
        imemREN = 1'b0;
    endtask

    task automatic test_reset();
        imemaddr = 32'h0;
        do_reset();
        cycle();
        #1;
        checks++;
        if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL reset_ihit: got %b expected 0", ihit); end
        checks++;
        if (imemload !== 32'd0) begin errors++; $display("[TB] FAIL reset_imemload: got %h expected 0", imemload); end
        checks++;
        if (iREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_iREN: got %b expected 0", iREN); end
        checks++;
        if (iaddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_iaddr: got %h expected 0", iaddr); end
    endtask

    task automatic test_cold_miss();
        do_reset();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL cold_first_ihit: got %b expected 0", ihit); end
        cycle();
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h40) begin
            errors++; $display("[TB] FAIL cold_word0: got iREN=%b iaddr=%h expected 1 00000040", iREN, iaddr);
        end
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'd0) begin
            errors++; $display("[TB] FAIL cold_refill_out: got ihit=%b load=%h expected 0 0", ihit, imemload);
        end
        cycle();
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            errors++; $display("[TB] FAIL cold_word1: got iREN=%b iaddr=%h expected 1 00000044", iREN, iaddr);
        end
        cycle();
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_0040 || iREN !== 1'b0) begin
            errors++; $display("[TB] FAIL cold_hit_A: got ihit=%b load=%h iREN=%b expected 1 10000040 0", ihit, imemload, iREN);
        end
        cycle();
        imemaddr = 32'h44;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_0044 || iREN !== 1'b0) begin
            errors++; $display("[TB] FAIL cold_hit_B: got ihit=%b load=%h iREN=%b expected 1 10000044 0", ihit, imemload, iREN);
        end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_lru();
        int cyc;
        do_reset();
        fill_line(32'h40, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("[TB] FAIL lru_fill40: got %0d expected 3", cyc); end
        cycle();
        fill_line(32'h80, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("[TB] FAIL lru_fill80: got %0d expected 3", cyc); end
        cycle();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_0040) begin
            errors++; $display("[TB] FAIL lru_touch40: got ihit=%b load=%h expected 1 10000040", ihit, imemload);
        end
        cycle();
        fill_line(32'hC0, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("[TB] FAIL lru_fillC0: got %0d expected 3", cyc); end
        cycle();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_0040) begin
            errors++; $display("[TB] FAIL lru_keep40: got ihit=%b load=%h expected 1 10000040", ihit, imemload);
        end
        imemaddr = 32'h80;
        #1;
        checks++;
        if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL lru_evict80: got ihit=%b expected 0", ihit); end
        imemaddr = 32'hC4;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_00C4) begin
            errors++; $display("[TB] FAIL lru_hitC4: got ihit=%b load=%h expected 1 100000c4", ihit, imemload);
        end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_iwait_stall();
        do_reset();
        iwait    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h100;
        #1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h100 || ihit !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_hold%0d: got iREN=%b iaddr=%h ihit=%b expected 1 00000100 0", i, iREN, iaddr, ihit);
            end
            cycle();
        end
        iwait = 1'b0;
        #1;
        cycle();
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h104) begin
            errors++; $display("[TB] FAIL stall_word1: got iREN=%b iaddr=%h expected 1 00000104", iREN, iaddr);
        end
        cycle();
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_0100) begin
            errors++; $display("[TB] FAIL stall_done: got ihit=%b load=%h expected 1 10000100", ihit, imemload);
        end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_ren_drop();
        do_reset();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        cycle();
        cycle();
        imemREN  = 1'b0;
        imemaddr = 32'h200;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h44 || ihit !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_word1: got iREN=%b iaddr=%h ihit=%b expected 1 00000044 0", iREN, iaddr, ihit);
        end
        cycle();
        #1;
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_idle: got iREN=%b ihit=%b expected 0 0", iREN, ihit);
        end
        imemREN  = 1'b1;
        imemaddr = 32'h44;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1000_0044 || iREN !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_hit44: got ihit=%b load=%h iREN=%b expected 1 10000044 0", ihit, imemload, iREN);
        end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_refill();
        int cyc;
        do_reset();
        fill_line(32'h40, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("[TB] FAIL rstmid_fill40: got %0d expected 3", cyc); end
        cycle();
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        #1;
        cycle();
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h80) begin
            errors++; $display("[TB] FAIL rstmid_refill: got iREN=%b iaddr=%h expected 1 00000080", iREN, iaddr);
        end
        nRST = 1'b0;
        cycle();
        nRST    = 1'b1;
        imemREN = 1'b0;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'd0 || ihit !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_outputs: got iREN=%b iaddr=%h ihit=%b expected 0 0 0", iREN, iaddr, ihit);
        end
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_40_gone: got ihit=%b expected 0", ihit); end
        imemaddr = 32'h80;
        #1;
        checks++;
        if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_80_partial: got ihit=%b expected 0", ihit); end
        imemREN = 1'b0;
        cycle();
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        int cyc;
        do_reset();
        #1;
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("[TB] FAIL stats_reset: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
        end
        cycle();
        fill_line(32'h40, cyc);
        cycle();
        fill_line(32'h80, cyc);
        cycle();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        cycle();
        cycle();
        cycle();
        imemREN = 1'b0;
        #1;
        checks++;
        if (miss_count !== 32'd2) begin errors++; $display("[TB] FAIL stats_miss: got %0d expected 2", miss_count); end
        checks++;
        if (hit_count !== 32'd3) begin errors++; $display("[TB] FAIL stats_hit: got %0d expected 3", hit_count); end
        cycle();
    endtask
`endif

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b0;
        $display("[TB] icache_assoc directed tests starting");
        test_reset();
        test_cold_miss();
        test_lru();
        test_iwait_stall();
        test_ren_drop();
        test_reset_mid_refill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
